// File: rtl/move_executor_pkg.sv
// Shared definitions for the move execution stage: register index codes,
// one-hot destination codes, FSM state encoding and small decode helpers.
package move_executor_pkg;

    // Source register index codes (3-bit, bit 2 set is an illegal encoding)
    localparam logic [2:0] REG_A = 3'b000;
    localparam logic [2:0] REG_B = 3'b001;
    localparam logic [2:0] REG_C = 3'b010;
    localparam logic [2:0] REG_D = 3'b011;

    // One-hot destination codes
    localparam logic [3:0] DST_A = 4'b0001;
    localparam logic [3:0] DST_B = 4'b0010;
    localparam logic [3:0] DST_C = 4'b0100;
    localparam logic [3:0] DST_D = 4'b1000;

    // Execution FSM states
    typedef enum logic [1:0] {
        MX_IDLE  = 2'd0,
        MX_READ  = 2'd1,
        MX_WRITE = 2'd2
    } mx_state_t;

    // A move is legal when the source is A..D, the destination is exactly
    // one-hot and the accumulator select agrees with the A destination bit.
    function automatic logic move_is_legal(input logic       acc_sel,
                                           input logic [2:0] src,
                                           input logic [3:0] dst);
        logic onehot;
        onehot = (dst == DST_A) || (dst == DST_B) ||
                 (dst == DST_C) || (dst == DST_D);
        return (src[2] == 1'b0) && onehot && (acc_sel == dst[0]);
    endfunction

    // Convert a one-hot destination to a 2-bit bank index (only meaningful
    // for legal, one-hot inputs).
    function automatic logic [1:0] dst_index(input logic [3:0] dst);
        logic [1:0] idx;
        case (dst)
            DST_B:   idx = 2'd1;
            DST_C:   idx = 2'd2;
            DST_D:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/move_executor_gp_register_bank.sv
// gp_register_bank: four general-purpose registers (A..D) with one
// combinational read port and two write ports. The move write port has
// priority over the external load port when both target the same register.
module gp_register_bank #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_rd_sel,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_mv_we,
    input  logic [1:0]            i_mv_sel,
    input  logic [DATA_WIDTH-1:0] i_mv_data,
    input  logic                  i_ld_we,
    input  logic [1:0]            i_ld_sel,
    input  logic [DATA_WIDTH-1:0] i_ld_data,
    output logic [DATA_WIDTH-1:0] o_reg_a,
    output logic [DATA_WIDTH-1:0] o_reg_b,
    output logic [DATA_WIDTH-1:0] o_reg_c,
    output logic [DATA_WIDTH-1:0] o_reg_d
);

    logic [DATA_WIDTH-1:0] r_bank [4];

    // Register writes: move port first, load port only if not colliding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i_mv_we && (i_mv_sel == 2'(i))) begin
                    r_bank[i] <= i_mv_data;
                end else if (i_ld_we && (i_ld_sel == 2'(i))) begin
                    r_bank[i] <= i_ld_data;
                end
            end
        end
    end

    // Single read mux
    always_comb begin
        o_rd_data = r_bank[i_rd_sel];
    end

    assign o_reg_a = r_bank[0];
    assign o_reg_b = r_bank[1];
    assign o_reg_c = r_bank[2];
    assign o_reg_d = r_bank[3];

endmodule

// File: rtl/move_executor.sv
// move_executor: executes decoded register-to-register moves over a
// valid/ready handshake (IDLE -> READ -> WRITE), flags illegal encodings,
// and exposes an external load port into the register bank.
// Optional feature macro: MOVE_EXEC_ZERO_FLAG_EN adds a registered
// zero_flag reflecting whether the last moved value was zero.
module move_executor
    import move_executor_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mv_valid,
    output logic                  mv_ready,
    input  logic                  acc_sel,
    input  logic [2:0]            source_reg_sel,
    input  logic [3:0]            destination_reg_flag,
    input  logic                  load_en,
    input  logic [1:0]            load_sel,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] reg_a,
    output logic [DATA_WIDTH-1:0] reg_b,
    output logic [DATA_WIDTH-1:0] reg_c,
    output logic [DATA_WIDTH-1:0] reg_d,
    output logic                  done,
    output logic                  err
`ifdef MOVE_EXEC_ZERO_FLAG_EN
    ,
    output logic                  zero_flag
`endif
);

    mx_state_t             r_state;
    logic [1:0]            r_src_q;
    logic [1:0]            r_dst_q;
    logic [DATA_WIDTH-1:0] r_tmp;
    logic                  r_done;
    logic                  r_err;

    logic                  w_legal;
    logic                  w_mv_we;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_legal  = move_is_legal(acc_sel, source_reg_sel, destination_reg_flag);
    // The bank is written on the edge that leaves WRITE
    assign w_mv_we  = (r_state == MX_WRITE);
    // Decoded straight from state so it rises together with async reset
    assign mv_ready = (r_state == MX_IDLE);

    gp_register_bank #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_rd_sel  (r_src_q),
        .o_rd_data (w_rd_data),
        .i_mv_we   (w_mv_we),
        .i_mv_sel  (r_dst_q),
        .i_mv_data (r_tmp),
        .i_ld_we   (load_en),
        .i_ld_sel  (load_sel),
        .i_ld_data (load_data),
        .o_reg_a   (reg_a),
        .o_reg_b   (reg_b),
        .o_reg_c   (reg_c),
        .o_reg_d   (reg_d)
    );

    // Move FSM: accept/legality check, source read into tmp, done/err pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MX_IDLE;
            r_src_q <= '0;
            r_dst_q <= '0;
            r_tmp   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                MX_IDLE: begin
                    if (mv_valid) begin
                        r_src_q <= source_reg_sel[1:0];
                        r_dst_q <= dst_index(destination_reg_flag);
                        if (w_legal) begin
                            r_state <= MX_READ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                MX_READ: begin
                    // Bank read is pre-edge, so a same-edge load is not seen
                    r_tmp   <= w_rd_data;
                    r_state <= MX_WRITE;
                end
                MX_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= MX_IDLE;
                end
                default: begin
                    r_state <= MX_IDLE;
                end
            endcase
        end
    end

    assign done = r_done;
    assign err  = r_err;

`ifdef MOVE_EXEC_ZERO_FLAG_EN
    logic r_zero;

    // Zero flag tracks the value written by the most recent completed move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (r_state == MX_WRITE) begin
            r_zero <= (r_tmp == '0);
        end
    end

    assign zero_flag = r_zero;
`endif

endmodule

// File: tb/tb_move_executor.sv
// Testbench for move_executor: directed steps with a scoreboard of expected
// register-bank snapshots, popped when the DUT signals done.
module tb_move_executor;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mv_valid;
    logic          mv_ready;
    logic          acc_sel;
    logic [2:0]    source_reg_sel;
    logic [3:0]    destination_reg_flag;
    logic          load_en;
    logic [1:0]    load_sel;
    logic [DW-1:0] load_data;
    logic [DW-1:0] reg_a, reg_b, reg_c, reg_d;
    logic          done;
    logic          err;
    logic          zf_obs;

`ifdef MOVE_EXEC_ZERO_FLAG_EN
    logic          zero_flag;
    assign zf_obs = zero_flag;
`else
    assign zf_obs = 1'b0;
`endif

    move_executor #(.DATA_WIDTH(DW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mv_valid             (mv_valid),
        .mv_ready             (mv_ready),
        .acc_sel              (acc_sel),
        .source_reg_sel       (source_reg_sel),
        .destination_reg_flag (destination_reg_flag),
        .load_en              (load_en),
        .load_sel             (load_sel),
        .load_data            (load_data),
        .reg_a                (reg_a),
        .reg_b                (reg_b),
        .reg_c                (reg_c),
        .reg_d                (reg_d),
        .done                 (done),
        .err                  (err)
`ifdef MOVE_EXEC_ZERO_FLAG_EN
        ,
        .zero_flag            (zero_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic       zf;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model [4];
    logic       zf_model;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_A"}, 32'(reg_a), 32'(model[0]));
        check({tag, "_B"}, 32'(reg_b), 32'(model[1]));
        check({tag, "_C"}, 32'(reg_c), 32'(model[2]));
        check({tag, "_D"}, 32'(reg_d), 32'(model[3]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [7:0] data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_data = data;
        tick();
        load_en   = 1'b0;
        model[sel] = data;
    endtask

    task automatic do_move(input string tag, input logic acc, input logic [2:0] src,
                           input logic [3:0] dst,
                           input logic rl_en, input logic [1:0] rl_sel, input logic [7:0] rl_d,
                           input logic wl_en, input logic [1:0] wl_sel, input logic [7:0] wl_d);
        logic       legal;
        logic [1:0] di;
        logic [7:0] tmp;
        exp_t       e;
        bit         seen;

        legal = (src[2] == 1'b0) && ($countones(dst) == 1) && (acc == dst[0]);
        check({tag, "_ready_pre"}, 32'(mv_ready), 32'd1);
        mv_valid             = 1'b1;
        acc_sel              = acc;
        source_reg_sel       = src;
        destination_reg_flag = dst;

        if (!legal) begin
            tick();
            mv_valid             = 1'b0;
            acc_sel              = 1'b0;
            source_reg_sel       = 3'b000;
            destination_reg_flag = 4'b0001;
            check({tag, "_err"}, 32'(err), 32'd1);
            check({tag, "_ready"}, 32'(mv_ready), 32'd1);
            check({tag, "_done"}, 32'(done), 32'd0);
            check_regs(tag);
`ifdef MOVE_EXEC_ZERO_FLAG_EN
            check({tag, "_zf"}, 32'(zf_obs), 32'(zf_model));
`endif
            tick();
            check({tag, "_err_low"}, 32'(err), 32'd0);
            return;
        end

        case (dst)
            4'b0010: di = 2'd1;
            4'b0100: di = 2'd2;
            4'b1000: di = 2'd3;
            default: di = 2'd0;
        endcase
        tmp = model[src[1:0]];
        if (rl_en) model[rl_sel] = rl_d;
        model[di] = tmp;
        if (wl_en && (wl_sel != di)) model[wl_sel] = wl_d;
        zf_model = (tmp == 8'h00);
        e = {model[0], model[1], model[2], model[3], zf_model};
        sb_q.push_back(e);

        tick();
        // Scramble the request fields: the DUT must have captured them
        mv_valid             = 1'b0;
        acc_sel              = ~acc;
        source_reg_sel       = 3'b111;
        destination_reg_flag = 4'b1111;
        check({tag, "_ready_busy"}, 32'(mv_ready), 32'd0);

        seen = 1'b0;
        for (int cyc = 1; cyc <= 6 && !seen; cyc++) begin
            load_en   = (cyc == 1) ? rl_en  : ((cyc == 2) ? wl_en : 1'b0);
            load_sel  = (cyc == 1) ? rl_sel : wl_sel;
            load_data = (cyc == 1) ? rl_d   : wl_d;
            tick();
            load_en = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(cyc), 32'd2);
                check({tag, "_err_clear"}, 32'(err), 32'd0);
                check({tag, "_ready_back"}, 32'(mv_ready), 32'd1);
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, "_A"}, 32'(reg_a), 32'(e.a));
                    check({tag, "_B"}, 32'(reg_b), 32'(e.b));
                    check({tag, "_C"}, 32'(reg_c), 32'(e.c));
                    check({tag, "_D"}, 32'(reg_d), 32'(e.d));
`ifdef MOVE_EXEC_ZERO_FLAG_EN
                    check({tag, "_zf"}, 32'(zf_obs), 32'(e.zf));
`endif
                end
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        mv_valid             = 1'b0;
        acc_sel              = 1'b0;
        source_reg_sel       = 3'b000;
        destination_reg_flag = 4'b0001;
        load_en              = 1'b0;
        load_sel             = 2'd0;
        load_data            = 8'h00;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        zf_model = 1'b0;

        // Reset state
        #1;
        check("rst_ready", 32'(mv_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check_regs("rst");
`ifdef MOVE_EXEC_ZERO_FLAG_EN
        check("rst_zf", 32'(zf_obs), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic move C <- B
        do_load(2'd1, 8'h5A);
        check_regs("load_b");
        do_move("mv_c_b", 1'b0, 3'b001, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

        // Illegal encodings
        do_move("ill_acc", 1'b1, 3'b000, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        do_move("ill_src_dst", 1'b0, 3'b100, 4'b0110, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        do_move("ill_noacc", 1'b0, 3'b001, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

        // Collision: load to A on the WRITE-exit edge of move A <- D
        do_load(2'd3, 8'h11);
        do_move("collide", 1'b1, 3'b011, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hFF);

        // Load to the source on the READ-exit edge
        do_load(2'd0, 8'h00);
        do_move("ld_src", 1'b1, 3'b011, 4'b0001, 1'b1, 2'd3, 8'h22, 1'b0, 2'd0, 8'h00);

        // Non-colliding load on the WRITE-exit edge still lands
        do_move("ld_other", 1'b0, 3'b010, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h77);

        // Source equals destination
        do_move("self", 1'b0, 3'b010, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

        // Zero flag sequence (flag compares only in the feature build)
        do_load(2'd2, 8'h00);
        do_move("zf_nz", 1'b1, 3'b001, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        do_move("zf_z", 1'b1, 3'b010, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        do_move("zf_ill", 1'b1, 3'b000, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        do_load(2'd0, 8'h05);
`ifdef MOVE_EXEC_ZERO_FLAG_EN
        check("zf_after_load", 32'(zf_obs), 32'd1);
`endif
        check_regs("after_zf");

        // Reset in the middle of a move (in READ)
        mv_valid             = 1'b1;
        acc_sel              = 1'b0;
        source_reg_sel       = 3'b001;
        destination_reg_flag = 4'b0100;
        tick();
        mv_valid = 1'b0;
        check("mid_busy", 32'(mv_ready), 32'd0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        zf_model = 1'b0;
        check("mid_rst_ready", 32'(mv_ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check_regs("mid_rst");
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("mid_no_done", 32'(done), 32'd0);
            tick();
        end
        check_regs("post_rst");
        do_move("post_b_a", 1'b0, 3'b000, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_executor.md
# move_executor

Sequential execution stage directly downstream of the move decoder. It accepts a decoded register-to-register move (`acc_sel`, `source_reg_sel`, `destination_reg_flag`) under a valid/ready handshake. It then reads the source from its four-entry general-purpose bank (A, B, C, D), writes the value to the destination two cycles later, and reports completion or an illegal encoding. It also provides a single external load port used by immediate and ALU write-back paths.

## Interface
- `DATA_WIDTH`, 8, width of each register A–D.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mv_valid` in 1: a decoded move request is present.
- `mv_ready` out 1: the block can accept a move; high only in IDLE.
- `acc_sel` in 1: destination is the accumulator (A).
- `source_reg_sel` in 3: source register; 000=A, 001=B, 010=C, 011=D; 1xx is illegal.
- `destination_reg_flag` in 4: one-hot destination; bit0=A, bit1=B, bit2=C, bit3=D.
- `load_en` in 1: external write strobe.
- `load_sel` in 2: external write target; 0=A, 1=B, 2=C, 3=D.
- `load_data` in DATA_WIDTH: external write data.
- `reg_a`, `reg_b`, `reg_c`, `reg_d` out DATA_WIDTH each: registered bank contents.
- `done` out 1: one-cycle pulse after the destination write.
- `err` out 1: one-cycle pulse when an illegal move is rejected.
- `zero_flag` out 1: present only with `MOVE_EXEC_ZERO_FLAG_EN`.

## Operation
- FSM states are IDLE, READ and WRITE; the reset state is IDLE.
- **Accept:** a move is accepted on a rising edge where `mv_valid && mv_ready`. Inputs are captured into internal `src_q` / `dst_q` at that edge. The inputs need not be held afterwards.
- **Legality check at accept.** A move is illegal if any of the following holds:
  - `source_reg_sel[2]` = 1;
  - `destination_reg_flag` is not exactly one-hot;
  - `acc_sel` ≠ `destination_reg_flag[0]`.
- **Illegal move:** the state stays IDLE, no register is written, and `err` pulses in the following cycle.
- **Legal move:** IDLE → READ → WRITE → IDLE.
  - On the edge leaving READ, `tmp` ← bank[`src_q`].
  - On the edge leaving WRITE, bank[`dst_q`] ← `tmp`, and `done` is registered high for the next cycle.
- **Source equals destination** (e.g. `source_reg_sel`=000, flag=0001) is legal. It completes normally with the value unchanged.
- **External load:** when `load_en` = 1, bank[`load_sel`] ← `load_data` on that edge, in any state.
- **Collision:** if a load and a move write target the same register on the same edge, the move write wins and the load is dropped. Loads to any other register take effect.
- **Load to the source on the READ-exit edge:** `tmp` captures the pre-edge (old) value.
- `mv_valid` while not ready is ignored; the requester must hold it until it sees `mv_ready`.

## Timing
- Reset values:
  - state = IDLE;
  - A–D = 0, `tmp` = 0;
  - `done` = 0, `err` = 0, `zero_flag` = 0;
  - `mv_ready` = 1 immediately on reset assertion (decoded from the async-reset state).
- **Latency:**
  - accept at edge N;
  - `tmp` loaded at N+1;
  - destination updated at N+2;
  - `done` high during cycle N+2 → N+3;
  - `mv_ready` is high again in cycle N+2 → N+3, so back-to-back moves are accepted every 3 cycles.
- **Illegal move:** `err` is high during cycle N → N+1. `mv_ready` stays high, so a new move can be accepted at N+1.
- `done` and `err` are never high in the same cycle.
- **Reset mid-operation:** the in-flight move is discarded with no partial write, and no `done` pulse is produced.

## Configuration
- Macro: `MOVE_EXEC_ZERO_FLAG_EN`.
- **Defined:**
  - `zero_flag` port exists.
  - It is registered and updated on the WRITE-exit edge to (`tmp` == 0).
  - It holds its value otherwise, including across external loads and illegal moves.
- **Undefined:** the port and its logic are absent, and all other behaviour is identical.

## Structure
- **Shared instructions header in `vh_files`:**
  - register index codes `REG_A`..`REG_D` (3-bit);
  - one-hot destination codes `DST_A`..`DST_D`;
  - FSM state encodings `MX_IDLE`, `MX_READ`, `MX_WRITE`.
- **Sub-module `gp_register_bank`:**
  - 4×DATA_WIDTH storage with async reset;
  - one read mux indexed by a 2-bit select;
  - move write port with priority over the load write port.
- The FSM, legality check, `tmp` and flags live in `move_executor`.

## Test plan
- **Basic move:** reset; load B=0x5A; move C←B (`src`=001, `dst`=0100, `acc_sel`=0) → C=0x5A at N+2, `done` pulse at N+2, B still 0x5A.
- **Illegal encodings:**
  - `acc_sel`=1 with `dst`=0010 → `err` pulse at N, no register changes, `mv_ready` stays 1;
  - repeat with `dst`=0110 and `src`=100 → same response.
- **Collision:** move A←D (D=0x11) with `load_en`, `load_sel`=0, `load_data`=0xFF on the WRITE-exit edge → A=0x11.
- **Load to source:** load D=0x22 on the READ-exit edge of the same move → A=0x11 (old value), D=0x22.
- **Reset mid-move:** assert `rst` in the READ state → all registers 0, `mv_ready`=1 immediately, no `done`. After release, a move B←A gives B=0x00 with `done`.
- **Zero flag** (`MOVE_EXEC_ZERO_FLAG_EN`): move A←C with C=0 → `zero_flag`=1; then move A←B with B=0x5A → `zero_flag`=0; an illegal move leaves `zero_flag` unchanged.
